// File: rtl/mbldcm_commutator.sv
// Six-step trapezoidal commutation sequencer for a 3-phase BLDC bridge.
// Routes iPwm to the active high-side gate and inserts all-off dead time at every step change.
module mbldcm_commutator #(
  parameter int unsigned pCounterWidth = 32,
  parameter int unsigned pDeadWidth    = 8
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iEnable,
  input  logic                     iDirection,
  input  logic [pCounterWidth-1:0] iStepPeriod,
  input  logic [pDeadWidth-1:0]    iDeadTime,
  input  logic                     iPwm,
  output logic                     oGateUH,
  output logic                     oGateUL,
  output logic                     oGateVH,
  output logic                     oGateVL,
  output logic                     oGateWH,
  output logic                     oGateWL,
  output logic [2:0]               oStep,
  output logic                     oStepPulse,
  output logic                     oBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    RUN  = 2'd2
  } tState;

  tState                    state, stateNext;
  logic [pCounterWidth-1:0] timer, timerNext;
  logic [pDeadWidth-1:0]    deadCnt, deadNext;
  logic [2:0]               stepNext;
  logic                     pulseNext;
  logic                     periodEnd;
  // Gate vector order: {UH, UL, VH, VL, WH, WL}
  logic [5:0]               gates, gatesNext;

  // State and output registers
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state      <= IDLE;
      timer      <= '0;
      deadCnt    <= '0;
      oStep      <= 3'd0;
      oStepPulse <= 1'b0;
      oBusy      <= 1'b0;
      gates      <= 6'd0;
    end else begin
      state      <= stateNext;
      timer      <= timerNext;
      deadCnt    <= deadNext;
      oStep      <= stepNext;
      oStepPulse <= pulseNext;
      oBusy      <= (stateNext != IDLE);
      gates      <= gatesNext;
    end
  end

  // Compare with >= so a period lowered below the running timer commutes at once
  assign periodEnd = (iStepPeriod != '0) && (timer >= (iStepPeriod - pCounterWidth'(1)));

  // Next-state, timer, dead counter and step sequencing; disable wins over commutation
  always_comb begin
    stateNext = state;
    timerNext = timer;
    deadNext  = deadCnt;
    stepNext  = oStep;
    pulseNext = 1'b0;
    if (!iEnable) begin
      stateNext = IDLE;
      timerNext = '0;
      deadNext  = '0;
    end else begin
      case (state)
        IDLE: begin
          timerNext = '0;
          deadNext  = iDeadTime;
          stateNext = (iDeadTime == '0) ? RUN : DEAD;
        end
        DEAD: begin
          timerNext = '0;
          deadNext  = deadCnt - pDeadWidth'(1);
          if (deadCnt <= pDeadWidth'(1)) begin
            stateNext = RUN;
            deadNext  = '0;
          end
        end
        RUN: begin
          if (iStepPeriod == '0) begin
            timerNext = '0;
          end else if (periodEnd) begin
            if (iDirection) stepNext = (oStep == 3'd0) ? 3'd5 : oStep - 3'd1;
            else            stepNext = (oStep == 3'd5) ? 3'd0 : oStep + 3'd1;
            pulseNext = 1'b1;
            timerNext = '0;
            deadNext  = iDeadTime;
            stateNext = (iDeadTime == '0) ? RUN : DEAD;
          end else begin
            timerNext = timer + pCounterWidth'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Commutation table: high phase follows iPwm, low phase held on, third phase floats
  always_comb begin
    gatesNext = 6'd0;
    if (iEnable && (state == RUN)) begin
      case (oStep)
        3'd0: begin gatesNext[5] = iPwm; gatesNext[2] = 1'b1; end
        3'd1: begin gatesNext[5] = iPwm; gatesNext[0] = 1'b1; end
        3'd2: begin gatesNext[3] = iPwm; gatesNext[0] = 1'b1; end
        3'd3: begin gatesNext[3] = iPwm; gatesNext[4] = 1'b1; end
        3'd4: begin gatesNext[1] = iPwm; gatesNext[4] = 1'b1; end
        3'd5: begin gatesNext[1] = iPwm; gatesNext[2] = 1'b1; end
        default: gatesNext = 6'd0;
      endcase
    end
  end

  assign oGateUH = gates[5];
  assign oGateUL = gates[4];
  assign oGateVH = gates[3];
  assign oGateVL = gates[2];
  assign oGateWH = gates[1];
  assign oGateWL = gates[0];

endmodule
